l1_controller: RTL
==================

L1_CONTROLLER -- requirements
Module: L1_controller

Interface
REQ-001 SHALL have parameter TNUM, default 18, meaning tag bits (address[31:14]).
REQ-002 SHALL have parameter INUM, default 26-TNUM, meaning index bits (address[13:6]; 64-byte block).
REQ-003 SHALL have the following ports:
- clk  in  1  sole clock.
- nrst  in  1  reset; synchronous, active-low.
- read_C_L1, write_C_L1  in  1  core request; held stable until ready_L1_C.
- tag_C_L1  in  TNUM  request tag.
- index_C_L1  in  INUM  request index.
- flush  in  1  invalidate-all request.
- ready_L1_C  out  1  one-cycle request-complete pulse.
- refill  out  1  one-cycle pulse: data array loads the L2 block into `way`.
- update  out  1  one-cycle pulse: data array writes core data into `way`.
- way  out  1  selected way (hit or victim).
- read_L1_L2, write_L1_L2  out  1  requests to L2_controller.
- tag_L1_L2  out  TNUM  refill tag.
- index_L1_L2  out  INUM  request index.
- write_tag_L1_L2  out  TNUM  victim tag for write-back.
- ready_L2_L1  in  1  L2 completion.
- hit_cnt, miss_cnt  out  32  performance counters.

Function
REQ-004 SHALL be 2-way set-associative with per-way valid, dirty and tag, 1-bit LRU per set, write-back and write-allocate.
REQ-005 SHALL implement states IDLE, COMPARE, WRITE_BACK, ALLOCATE.
REQ-006 SHALL in IDLE, on read_C_L1|write_C_L1, go to COMPARE next cycle; with both asserted, treat the request as a read.
REQ-007 SHALL on a COMPARE hit:
- pulse ready_L1_C and drive way to the hit way;
- for a write, also pulse update, set dirty and set LRU to the other way;
- return to IDLE.
- Hit latency is 2 cycles from request to ready_L1_C.
REQ-008 SHALL on a COMPARE miss pick the victim as: lowest-numbered invalid way, else the LRU way. A dirty victim goes to WRITE_BACK; otherwise to ALLOCATE.
REQ-009 SHALL in WRITE_BACK hold write_L1_L2=1, write_tag_L1_L2=victim tag and index_L1_L2=index until the cycle ready_L2_L1=1, then go to ALLOCATE.
REQ-010 SHALL in ALLOCATE hold read_L1_L2=1 and tag_L1_L2=request tag until ready_L2_L1=1. That same cycle it SHALL:
- pulse refill;
- install the tag with valid=1, dirty=0;
- go to COMPARE, whose re-check then hits.
REQ-011 SHALL keep read_L1_L2 and write_L1_L2 mutually exclusive, and ignore ready_L2_L1 in IDLE and COMPARE.
REQ-012 SHALL sample flush only in IDLE, where it has priority over read and write. It SHALL clear all valid, dirty and LRU bits in one cycle, with no write-back and no ready_L1_C. Outside IDLE, flush is ignored.
REQ-013 SHALL hold way, tag_L1_L2, index_L1_L2 and write_tag_L1_L2 stable from miss detection until refill.

Reset
REQ-014 SHALL, on nrst=0 at a clk edge, from any state (including mid-WRITE_BACK/ALLOCATE), enter IDLE and clear all valid, dirty and LRU bits. All outputs SHALL be 0 during and after reset.

Configuration
REQ-015 SHALL use macro L1_PERF_CNT_EN.
- Defined: hit_cnt increments on the first COMPARE of a request that hits; miss_cnt on the first COMPARE that misses (the post-refill re-check counts as neither). Both counters saturate at 32'hFFFF_FFFF, clear on reset and are unaffected by flush.
- Undefined: both ports are tied to 0 and no counter logic is present.

Structure
REQ-016 SHALL take TNUM/INUM defaults, NWAY=2 and the state enum from shared package L1_pkg.
REQ-017 SHALL place tag/valid/dirty/LRU storage, with single-cycle flush clear, in sub-module L1_tag_array.

Verification
REQ-018 Cold read 0x1234_5040 -> read_L1_L2 with tag 0x048D1 and index 0x41; ready_L2_L1 after 4 cycles -> refill with way=0, then ready_L1_C 1 cycle later.
REQ-019 Repeat read of 0x1234_5040 -> ready_L1_C 2 cycles after request, way=0, no L2 traffic.
REQ-020 Write hit on way0, then misses with two new tags at index 0x41 -> second miss evicts way0 (LRU) with write_L1_L2=1 and write_tag_L1_L2=0x048D1 before read_L1_L2.
REQ-021 Flush asserted together with a read in IDLE -> all lines invalid, no ready_L1_C; the following read of 0x1234_5040 misses.
REQ-022 nrst=0 during ALLOCATE -> next cycle IDLE, read_L1_L2=0, all outputs 0; a later request misses.
REQ-023 With L1_PERF_CNT_EN: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3. Without the macro, both stay 0.

Source files
------------

// File: rtl/l1_controller_pkg.sv
// Shared definitions for the L1 cache controller: address split defaults,
// associativity, controller state encoding and the victim-selection rule.
package L1_pkg;

   // Tag plus index bits cover address[31:6]; the block offset is 6 bits.
   localparam int L1_TNUM    = 18;
   localparam int L1_TI_BITS = 26;
   localparam int L1_INUM    = L1_TI_BITS - L1_TNUM;
   localparam int NWAY       = 2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COMPARE    = 2'd1,
      WRITE_BACK = 2'd2,
      ALLOCATE   = 2'd3
   } l1_state_t;

   // Lowest-numbered invalid way wins; with both ways valid, the LRU way goes.
   function automatic logic pick_victim(input logic [NWAY-1:0] valid, input logic lru);
      if (!valid[0]) return 1'b0;
      if (!valid[1]) return 1'b1;
      return lru;
   endfunction

endpackage

// File: rtl/l1_controller_tag_array.sv
// Tag, valid, dirty and LRU storage for the 2-way L1. Valid/dirty/LRU live in
// flops so a flush (or reset) clears every set in a single cycle; tags are
// never cleared because they are meaningless while their valid bit is 0.
module L1_tag_array
   import L1_pkg::*;
#(
   parameter int TNUM = L1_TNUM,
   parameter int INUM = L1_INUM
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       clear,
   input  logic [INUM-1:0]            index,
   output logic [NWAY-1:0][TNUM-1:0]  tags,
   output logic [NWAY-1:0]            valid,
   output logic [NWAY-1:0]            dirty,
   output logic                       lru,
   input  logic                       touch,
   input  logic                       touch_way,
   input  logic                       mark_dirty,
   input  logic                       install,
   input  logic                       install_way,
   input  logic [TNUM-1:0]            install_tag
);

   localparam int SETS = 1 << INUM;

   logic [NWAY-1:0][TNUM-1:0] tag_mem [SETS];
   logic [SETS-1:0][NWAY-1:0] valid_q;
   logic [SETS-1:0][NWAY-1:0] dirty_q;
   logic [SETS-1:0]           lru_q;

   assign tags  = tag_mem[index];
   assign valid = valid_q[index];
   assign dirty = dirty_q[index];
   assign lru   = lru_q[index];

   // Tag write on refill only.
   always_ff @(posedge clk) begin
      if (install) tag_mem[index][install_way] <= install_tag;
   end

   // Status bits: reset/flush wipe everything, refill installs a clean line,
   // a hit marks the other way as LRU and optionally dirties the hit way.
   always_ff @(posedge clk) begin
      if (!nrst || clear) begin
         valid_q <= '0;
         dirty_q <= '0;
         lru_q   <= '0;
      end else begin
         if (install) begin
            valid_q[index][install_way] <= 1'b1;
            dirty_q[index][install_way] <= 1'b0;
         end
         if (touch) begin
            lru_q[index] <= ~touch_way;
            if (mark_dirty) dirty_q[index][touch_way] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_controller.sv
// L1 cache controller: 2-way set-associative, write-back, write-allocate,
// 1-bit LRU per set. Requests are latched in IDLE and resolved in COMPARE;
// misses optionally write back the dirty victim before refilling from L2.
// Optional feature macro: L1_PERF_CNT_EN enables saturating hit/miss counters;
// without it hit_cnt/miss_cnt are tied to zero.
module l1_controller
   import L1_pkg::*;
#(
   parameter int TNUM = L1_TNUM,
   parameter int INUM = L1_TI_BITS - TNUM
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            read_C_L1,
   input  logic            write_C_L1,
   input  logic [TNUM-1:0] tag_C_L1,
   input  logic [INUM-1:0] index_C_L1,
   input  logic            flush,
   output logic            ready_L1_C,
   output logic            refill,
   output logic            update,
   output logic            way,
   output logic            read_L1_L2,
   output logic            write_L1_L2,
   output logic [TNUM-1:0] tag_L1_L2,
   output logic [INUM-1:0] index_L1_L2,
   output logic [TNUM-1:0] write_tag_L1_L2,
   input  logic            ready_L2_L1,
   output logic [31:0]     hit_cnt,
   output logic [31:0]     miss_cnt
);

   l1_state_t state;

   logic [TNUM-1:0]           req_tag;
   logic [INUM-1:0]           req_idx;
   logic                      req_wr;

   logic [NWAY-1:0][TNUM-1:0] set_tags;
   logic [NWAY-1:0]           set_valid;
   logic [NWAY-1:0]           set_dirty;
   logic                      set_lru;
   logic [NWAY-1:0]           way_hit;
   logic                      hit;
   logic                      hit_way;
   logic                      victim;
   logic                      do_clear;
   logic                      do_touch;
   logic                      do_install;

   L1_tag_array #(.TNUM(TNUM), .INUM(INUM)) u_tags (
      .clk         (clk),
      .nrst        (nrst),
      .clear       (do_clear),
      .index       (req_idx),
      .tags        (set_tags),
      .valid       (set_valid),
      .dirty       (set_dirty),
      .lru         (set_lru),
      .touch       (do_touch),
      .touch_way   (hit_way),
      .mark_dirty  (req_wr),
      .install     (do_install),
      .install_way (way),
      .install_tag (req_tag)
   );

   // Hit detection and victim choice for the latched request's set.
   always_comb begin
      for (int w = 0; w < NWAY; w++)
         way_hit[w] = set_valid[w] && (set_tags[w] == req_tag);
      hit        = |way_hit;
      hit_way    = ~way_hit[0];
      victim     = pick_victim(set_valid, set_lru);
      do_clear   = (state == IDLE) && flush;
      do_touch   = (state == COMPARE) && hit;
      do_install = (state == ALLOCATE) && ready_L2_L1;
   end

   // Controller FSM with registered outputs; L2-side outputs hold from miss
   // detection through refill because only the miss branch reloads them.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state           <= IDLE;
         req_tag         <= '0;
         req_idx         <= '0;
         req_wr          <= 1'b0;
         ready_L1_C      <= 1'b0;
         refill          <= 1'b0;
         update          <= 1'b0;
         way             <= 1'b0;
         read_L1_L2      <= 1'b0;
         write_L1_L2     <= 1'b0;
         tag_L1_L2       <= '0;
         index_L1_L2     <= '0;
         write_tag_L1_L2 <= '0;
      end else begin
         ready_L1_C <= 1'b0;
         refill     <= 1'b0;
         update     <= 1'b0;
         case (state)
            IDLE: begin
               // Flush wins over a simultaneous request; the request stays
               // pending on the core side and is picked up next cycle.
               if (!flush && (read_C_L1 || write_C_L1)) begin
                  req_tag <= tag_C_L1;
                  req_idx <= index_C_L1;
                  req_wr  <= write_C_L1 & ~read_C_L1;
                  state   <= COMPARE;
               end
            end
            COMPARE: begin
               if (hit) begin
                  ready_L1_C <= 1'b1;
                  way        <= hit_way;
                  update     <= req_wr;
                  state      <= IDLE;
               end else begin
                  way             <= victim;
                  tag_L1_L2       <= req_tag;
                  index_L1_L2     <= req_idx;
                  write_tag_L1_L2 <= set_tags[victim];
                  if (set_valid[victim] && set_dirty[victim]) begin
                     write_L1_L2 <= 1'b1;
                     state       <= WRITE_BACK;
                  end else begin
                     read_L1_L2  <= 1'b1;
                     state       <= ALLOCATE;
                  end
               end
            end
            WRITE_BACK: begin
               if (ready_L2_L1) begin
                  write_L1_L2 <= 1'b0;
                  read_L1_L2  <= 1'b1;
                  state       <= ALLOCATE;
               end
            end
            ALLOCATE: begin
               if (ready_L2_L1) begin
                  read_L1_L2 <= 1'b0;
                  refill     <= 1'b1;
                  state      <= COMPARE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef L1_PERF_CNT_EN
   logic recheck;

   // Marks the COMPARE that follows a refill so it is not counted again.
   always_ff @(posedge clk) begin
      if (!nrst)                                    recheck <= 1'b0;
      else if ((state == ALLOCATE) && ready_L2_L1)  recheck <= 1'b1;
      else if (state == IDLE)                       recheck <= 1'b0;
   end

   // Saturating counters, one event per request on its first lookup.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if ((state == COMPARE) && !recheck) begin
         if (hit) begin
            if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
         end else begin
            if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule
